// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
//   Shared definitions for the logic_unit_pipe block:
//     LU_OP_W    - opcode width (fixed at 3)
//     LU_FLAG_W  - number of status flags carried by the output stage
//     lu_op_e    - opcode encoding. op[1:0] selects the base function
//                  (AND / OR / XOR / NOT-B) and op[2] inverts it, which is
//                  why NAND/NOR/XNOR/PASSB sit exactly 4 codes above their
//                  base functions.
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  localparam int LU_OP_W   = 3;
  localparam int LU_FLAG_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND   = 3'b000,
    LU_OR    = 3'b001,
    LU_XOR   = 3'b010,
    LU_NOTB  = 3'b011,
    LU_NAND  = 3'b100,
    LU_NOR   = 3'b101,
    LU_XNOR  = 3'b110,
    LU_PASSB = 3'b111
  } lu_op_e;

endpackage

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
//   One valid/ready register slice. Accepts a new word whenever it is empty
//   or its current word leaves downstream in the same cycle, so a chain of
//   these sustains one transfer per clock with no bubbles.
//
//   Parameters:
//     DW         - data width in bits
//   Ports:
//     clk        - clock, rising edge
//     rst_n      - asynchronous active-low reset; clears valid and data
//     in_valid   - upstream word is valid
//     in_ready   - slice will take the upstream word this cycle
//     in_data    - upstream word
//     out_valid  - slice holds a valid word
//     out_ready  - downstream takes the word this cycle
//     out_data   - held word
// ---------------------------------------------------------------------------
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  // Ready depends only on our own occupancy and the downstream ready,
  // never on in_valid, so no combinational loop can form through valid.
  assign in_ready = !valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      // Either empty or draining: take whatever is offered. With no upstream
      // word the stage empties; the data register keeps its stale value.
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//   Two-stage valid/ready pipelined bitwise logic unit.
//     Stage 1 registers {op, a, b}.
//     The bitwise function is evaluated between the stages.
//     Stage 2 registers the result (and flags, when enabled).
//   Latency is two cycles; throughput is one transaction per cycle.
//
//   Build option:
//     LOGIC_UNIT_PIPE_FLAGS_EN - when defined, flag_zero / flag_parity /
//       flag_ones are computed and registered alongside the result.
//       Otherwise the flag outputs are constant 0 and no flag storage
//       exists; the port list is the same in both builds.
//
//   Parameters:
//     WIDTH      - operand/result width, 1..64
//     OP_W       - opcode width, must be 3
//   Ports:
//     clk        - clock, rising edge
//     rst_n      - asynchronous active-low reset
//     a, b       - operands
//     op         - operation select (see logic_unit_pkg::lu_op_e)
//     in_valid   - a/b/op are valid
//     in_ready   - input transfer accepted this cycle
//     out_valid  - result/flags are valid
//     out_ready  - consumer takes the result this cycle
//     result     - logic result
//     flag_zero  - result == 0
//     flag_parity- XOR of all result bits
//     flag_ones  - result is all ones
// ---------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = LU_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_parity,
  output logic             flag_ones
);

  // Elaboration-time legality checks.
  if (OP_W != LU_OP_W) begin : g_bad_op_w
    $error("logic_unit_pipe: OP_W must be 3");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be in 1..64");
  end

  // -------------------------------------------------------------------------
  // Stage 1: operand register
  // -------------------------------------------------------------------------
  localparam int S1_W = 2 * WIDTH + OP_W;

  logic [S1_W-1:0]  s1_in_data;
  logic [S1_W-1:0]  s1_out_data;
  logic             s1_valid;
  logic             s1_adv;       // stage 2 can take stage 1's word
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;

  assign s1_in_data = {op, a, b};

  pipe_stage #(
    .DW (S1_W)
  ) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s1_adv),
    .out_data  (s1_out_data)
  );

  assign {s1_op, s1_a, s1_b} = s1_out_data;

  // -------------------------------------------------------------------------
  // Bitwise function between the stages
  // -------------------------------------------------------------------------
  lu_op_e           s1_op_e;
  logic [WIDTH-1:0] lu_res;

  assign s1_op_e = lu_op_e'(s1_op);

  always_comb begin
    lu_res = '0;
    case (s1_op_e)
      LU_AND:   lu_res = s1_a & s1_b;
      LU_OR:    lu_res = s1_a | s1_b;
      LU_XOR:   lu_res = s1_a ^ s1_b;
      LU_NOTB:  lu_res = ~s1_b;
      LU_NAND:  lu_res = ~(s1_a & s1_b);
      LU_NOR:   lu_res = ~(s1_a | s1_b);
      LU_XNOR:  lu_res = ~(s1_a ^ s1_b);
      LU_PASSB: lu_res = s1_b;
      default:  lu_res = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 2: result (+ flags) register
  // -------------------------------------------------------------------------
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  localparam int S2_W = WIDTH + LU_FLAG_W;

  logic [S2_W-1:0] s2_in_data;
  logic [S2_W-1:0] s2_out_data;

  // Flags are derived from the combinational result so they register in the
  // same cycle as the result they describe.
  assign s2_in_data = {(lu_res == '0), (^lu_res), (&lu_res), lu_res};

  assign {flag_zero, flag_parity, flag_ones, result} = s2_out_data;
`else
  localparam int S2_W = WIDTH;

  logic [S2_W-1:0] s2_in_data;
  logic [S2_W-1:0] s2_out_data;

  assign s2_in_data  = lu_res;
  assign result      = s2_out_data;
  assign flag_zero   = 1'b0;
  assign flag_parity = 1'b0;
  assign flag_ones   = 1'b0;
`endif

  pipe_stage #(
    .DW (S2_W)
  ) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s1_adv),
    .in_data   (s2_in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out_data)
  );

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Drives three copies of logic_unit_pipe (WIDTH = 8, 1 and 64) from one
//   shared stimulus stream. The reference model is a queue of accepted
//   transactions: an item becomes visible at the output one edge after it
//   was accepted and leaves on an output transfer; the pipe holds at most
//   two items, so input is ready while fewer than two are in flight or the
//   head is leaving. Results are computed from the opcode table directly.
// ---------------------------------------------------------------------------
module tb_logic_unit_pipe;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    int          acc;
  } txn_t;

  typedef struct {
    logic [7:0] res;
    logic       fz;
    logic       fp;
    logic       fo;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [2:0]  op;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready8, out_valid8, fz8, fp8, fo8;
  logic [7:0]  result8;
  logic        in_ready1, out_valid1, fz1, fp1, fo1;
  logic [0:0]  result1;
  logic        in_ready64, out_valid64, fz64, fp64, fo64;
  logic [63:0] result64;

  txn_t q[$];
  obs_t obs_log[$];
  int   cyc;
  int   n_acc;
  int   n_total;
  int   n_bad;

  logic_unit_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .a(a64[7:0]), .b(b64[7:0]), .op(op),
    .in_valid(in_valid), .in_ready(in_ready8), .out_valid(out_valid8),
    .out_ready(out_ready), .result(result8), .flag_zero(fz8),
    .flag_parity(fp8), .flag_ones(fo8)
  );

  logic_unit_pipe #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a64[0:0]), .b(b64[0:0]), .op(op),
    .in_valid(in_valid), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_ready(out_ready), .result(result1), .flag_zero(fz1),
    .flag_parity(fp1), .flag_ones(fo1)
  );

  logic_unit_pipe #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .a(a64), .b(b64), .op(op),
    .in_valid(in_valid), .in_ready(in_ready64), .out_valid(out_valid64),
    .out_ready(out_ready), .result(result64), .flag_zero(fz64),
    .flag_parity(fp64), .flag_ones(fo64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] lu_ref(input logic [63:0] x, input logic [63:0] y,
                                         input logic [2:0] o);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~y;
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~(x ^ y);
      default: return y;
    endcase
  endfunction

  function automatic logic [63:0] width_mask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic exp_out_valid();
    return (q.size() != 0) && ((cyc - q[0].acc) >= 1);
  endfunction

  // Compare one instance against the model head.
  task automatic check_inst(input string tag, input int w, input logic ov,
                            input logic [63:0] res, input logic fz,
                            input logic fp, input logic fo);
    logic [63:0] m, r;
    logic        ez, ep, eo;
    logic        ovx;
    ovx = exp_out_valid();
    check_eq({tag, ".out_valid"}, {63'd0, ov}, {63'd0, ovx});
    if (ovx) begin
      m = width_mask(w);
      r = lu_ref(q[0].a, q[0].b, q[0].op) & m;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
      ez = (r == 64'd0);
      ep = ^r;
      eo = (r == m);
`else
      ez = 1'b0;
      ep = 1'b0;
      eo = 1'b0;
`endif
      check_eq({tag, ".result"}, res, r);
      check_eq({tag, ".flags"}, {61'd0, fz, fp, fo}, {61'd0, ez, ep, eo});
    end
  endtask

  task automatic check_outputs();
    check_inst("w8",  8,  out_valid8,  {56'd0, result8}, fz8,  fp8,  fo8);
    check_inst("w1",  1,  out_valid1,  {63'd0, result1}, fz1,  fp1,  fo1);
    check_inst("w64", 64, out_valid64, result64,         fz64, fp64, fo64);
  endtask

  // One clock: inputs are already driven (at the preceding negedge).
  task automatic step();
    logic ir_exp, acc_in, acc_out;
    #1;
    ir_exp = (q.size() < 2) || out_ready;
    check_eq("w8.in_ready",  {63'd0, in_ready8},  {63'd0, ir_exp});
    check_eq("w1.in_ready",  {63'd0, in_ready1},  {63'd0, ir_exp});
    check_eq("w64.in_ready", {63'd0, in_ready64}, {63'd0, ir_exp});
    acc_out = exp_out_valid() && out_ready;
    acc_in  = in_valid && ir_exp;
    if (out_valid8 && out_ready)
      obs_log.push_back('{res: result8, fz: fz8, fp: fp8, fo: fo8});
    if (in_valid && in_ready8)
      n_acc++;
    @(posedge clk);
    cyc++;
    if (acc_out) q.delete(0);
    if (acc_in) q.push_back('{a: a64, b: b64, op: op, acc: cyc});
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic [63:0] x,
                       input logic [63:0] y, input logic [2:0] o);
    in_valid  = iv;
    out_ready = ordy;
    a64       = x;
    b64       = y;
    op        = o;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 64'd0, 64'd0, 3'd0);
      step();
    end
  endtask

  initial begin : main
    logic [7:0] sweep_exp [8];
    logic [7:0] rv;
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;
    n_acc   = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 64'd0, 3'd0);
    sweep_exp = '{8'h30, 8'hFC, 8'hCC, 8'hC3, 8'hCF, 8'h03, 8'h33, 8'h3C};

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst.in_ready",  {63'd0, in_ready8},  64'd1);
    check_eq("rst.out_valid", {63'd0, out_valid8}, 64'd0);
    check_eq("rst.result",    {56'd0, result8},    64'd0);
    check_eq("rst.flags",     {61'd0, fz8, fp8, fo8}, 64'd0);
    rst_n = 1'b1;

    // Opcode sweep, unstalled, a=F0 b=3C
    obs_log.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 64'hFFFF_0000_1234_56F0, 64'h0F0F_F0F0_AAAA_553C, 3'(i));
      step();
    end
    drain(4);
    check_eq("sweep.count", 64'(obs_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs_log.size(); i++)
      check_eq($sformatf("sweep.op%0d", i), {56'd0, obs_log[i].res}, {56'd0, sweep_exp[i]});

    // Flag corner cases, a=AA b=55
    obs_log.delete();
    drive(1'b1, 1'b1, 64'hAA, 64'h55, 3'd0);
    step();
    drive(1'b1, 1'b1, 64'hAA, 64'h55, 3'd1);
    step();
    drain(4);
    check_eq("flags.count", 64'(obs_log.size()), 64'd2);
    if (obs_log.size() == 2) begin
      check_eq("flags.and_res", {56'd0, obs_log[0].res}, 64'h00);
      check_eq("flags.or_res",  {56'd0, obs_log[1].res}, 64'hFF);
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
      check_eq("flags.and_zp", {62'd0, obs_log[0].fz, obs_log[0].fp}, 64'b10);
      check_eq("flags.or_ones", {63'd0, obs_log[1].fo}, 64'd1);
`else
      check_eq("flags.and_zp", {62'd0, obs_log[0].fz, obs_log[0].fp}, 64'b00);
      check_eq("flags.or_ones", {63'd0, obs_log[1].fo}, 64'd0);
`endif
    end

    // Stall: out_ready low for 5 cycles with in_valid held
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
      step();
    end
    check_eq("stall.accepted", 64'(n_acc), 64'd2);
    #1;
    check_eq("stall.in_ready", {63'd0, in_ready8}, 64'd0);
    drain(4);

    // Reset mid-stream with both stages full
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
      step();
    end
    check_eq("prerst.out_valid", {63'd0, out_valid8}, 64'd1);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("midrst.out_valid", {63'd0, out_valid8}, 64'd0);
    check_eq("midrst.in_ready",  {63'd0, in_ready8},  64'd1);
    check_eq("midrst.result",    {56'd0, result8},    64'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    drain(3);

    // Random traffic with random back-pressure
    for (int i = 0; i < 1000; i++) begin
      drive(($urandom % 4) != 0, ($urandom % 3) != 0, {$urandom, $urandom},
            {$urandom, $urandom}, 3'($urandom_range(0, 7)));
      step();
    end
    drain(4);
    check_eq("final.empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
